// File: rtl/fir_out_decim_pkg.sv
// Shared constants and arithmetic helpers for the FIR output decimator.
// Rounding and clamping work on a wide signed intermediate so that any legal IN_WIDTH fits.
package fir_out_decim_pkg;

  localparam int CHIDX_WIDTH = 4;
  localparam int CALC_WIDTH  = 33;

  typedef logic signed [CALC_WIDTH-1:0] calc_t;

  typedef struct packed {
    logic  ovf;
    calc_t value;
  } sat_t;

  // Round-half-up arithmetic right shift.
  function automatic calc_t round_shift(input calc_t x, input logic [4:0] shift);
    calc_t bias;
    bias = '0;
    if (shift != 5'd0) bias = calc_t'(1) <<< (shift - 5'd1);
    return (x + bias) >>> shift;
  endfunction

  // Clamp to the signed range of out_width bits and flag when clamping happened.
  function automatic sat_t saturate(input calc_t r, input int out_width);
    calc_t hi;
    calc_t lo;
    sat_t  res;
    hi = (calc_t'(1) <<< (out_width - 1)) - calc_t'(1);
    lo = -hi - calc_t'(1);
    res.ovf   = (r > hi) || (r < lo);
    res.value = (r > hi) ? hi : ((r < lo) ? lo : r);
    return res;
  endfunction

endpackage

// File: rtl/fir_out_decim_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module fir_out_decim_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             accepted,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             pop_ok;

  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign pop_ok   = pop && !empty;
  assign accepted = push && (!full || pop_ok);
  assign head     = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge CLK) begin
    if (accepted) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (accepted) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({accepted, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_decim.sv
// FIR output stage: edge capture, per-channel decimation, round/narrow, FWFT output FIFO.
// Define FIR_OUT_DECIM_SAT_EN to clamp out-of-range samples (and flag Ovf_Sticky) instead of wrapping.
module fir_out_decim
  import fir_out_decim_pkg::*;
#(
  parameter int IN_WIDTH     = 24,
  parameter int OUT_WIDTH    = 16,
  parameter int MAX_CHANNELS = 2,
  parameter int DEC_WIDTH    = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DEC_WIDTH-1:0]   Dec_Factor,
  input  logic [4:0]             Shift,
  input  logic                   Status_Clr,
  input  logic [IN_WIDTH-1:0]    Data_In,
  input  logic                   Data_In_Valid,
  input  logic [CHIDX_WIDTH-1:0] Data_In_ChIdx,
  output logic [OUT_WIDTH-1:0]   Data_Out,
  output logic [CHIDX_WIDTH-1:0] Data_Out_ChIdx,
  output logic                   Data_Out_Valid,
  input  logic                   Data_Out_Ready,
  output logic [15:0]            Drop_Cnt,
  output logic                   Ovf_Sticky
);

  localparam int FW = OUT_WIDTH + CHIDX_WIDTH;

  logic                       valid_prev_reg;
  logic                       s0_valid_reg;
  logic signed [IN_WIDTH-1:0] s0_data_reg;
  logic [CHIDX_WIDTH-1:0]     s0_ch_reg;
  logic [DEC_WIDTH-1:0]       dec_reg;
  logic                       dec_changed;
  logic [DEC_WIDTH-1:0]       dec_load;
  logic [MAX_CHANNELS-1:0]    ch_sel;
  logic [MAX_CHANNELS-1:0]    ch_zero;
  logic                       keep;
  calc_t                      x_ext;
  calc_t                      rounded;
  logic [OUT_WIDTH-1:0]       narrow;
  logic                       s1_valid_reg;
  logic [OUT_WIDTH-1:0]       s1_data_reg;
  logic [CHIDX_WIDTH-1:0]     s1_ch_reg;
  logic [15:0]                drop_cnt_reg;
  logic                       push_ok;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [FW-1:0]              fifo_head;

  // S0: one capture per rising edge of the level-valid; out-of-range channels vanish here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_prev_reg <= 1'b0;
      s0_valid_reg   <= 1'b0;
      s0_data_reg    <= '0;
      s0_ch_reg      <= '0;
      dec_reg        <= '0;
    end else begin
      valid_prev_reg <= Data_In_Valid;
      s0_valid_reg   <= Data_In_Valid && !valid_prev_reg &&
                        ({1'b0, Data_In_ChIdx} < 5'(MAX_CHANNELS));
      s0_data_reg    <= Data_In;
      s0_ch_reg      <= Data_In_ChIdx;
      dec_reg        <= Dec_Factor;
    end
  end

  assign dec_changed = (Dec_Factor != dec_reg);
  assign dec_load    = (Dec_Factor == '0) ? '0 : Dec_Factor - 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_CHANNELS; gi++) begin : g_phase
      logic [DEC_WIDTH-1:0] phase_reg;
      assign ch_sel[gi]  = s0_valid_reg && (s0_ch_reg == CHIDX_WIDTH'(gi));
      assign ch_zero[gi] = (phase_reg == '0);
      always_ff @(posedge CLK) begin
        if (RST || dec_changed)
          phase_reg <= '0;
        else if (ch_sel[gi])
          phase_reg <= ch_zero[gi] ? dec_load : phase_reg - 1'b1;
      end
    end
  endgenerate

  assign keep    = |(ch_sel & ch_zero);
  assign x_ext   = calc_t'(s0_data_reg);
  assign rounded = round_shift(x_ext, Shift);

`ifdef FIR_OUT_DECIM_SAT_EN
  sat_t sat;
  logic ovf_reg;
  assign sat    = saturate(rounded, OUT_WIDTH);
  assign narrow = OUT_WIDTH'(sat.value);

  always_ff @(posedge CLK) begin
    if (RST || Status_Clr) ovf_reg <= 1'b0;
    else if (keep && sat.ovf) ovf_reg <= 1'b1;
  end
  assign Ovf_Sticky = ovf_reg;
`else
  assign narrow     = OUT_WIDTH'(rounded);
  assign Ovf_Sticky = 1'b0;
`endif

  // S1: registered kept sample, already narrowed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_ch_reg    <= '0;
    end else begin
      s1_valid_reg <= keep;
      s1_data_reg  <= narrow;
      s1_ch_reg    <= s0_ch_reg;
    end
  end

  fir_out_decim_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (s1_valid_reg),
    .push_data ({s1_ch_reg, s1_data_reg}),
    .pop       (Data_Out_Ready),
    .accepted  (push_ok),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // S2: a push the FIFO cannot take is counted; a clear in the same cycle wins.
  always_ff @(posedge CLK) begin
    if (RST || Status_Clr)
      drop_cnt_reg <= '0;
    else if (s1_valid_reg && !push_ok && (drop_cnt_reg != 16'hFFFF))
      drop_cnt_reg <= drop_cnt_reg + 1'b1;
  end

  assign Data_Out       = fifo_head[OUT_WIDTH-1:0];
  assign Data_Out_ChIdx = fifo_head[FW-1:OUT_WIDTH];
  assign Data_Out_Valid = !fifo_empty;
  assign Drop_Cnt       = drop_cnt_reg;

endmodule

// File: tb/tb_fir_out_decim.sv
// Scoreboard bench for fir_out_decim: stimulus pushes expected words, a monitor checks each pop.
module tb_fir_out_decim;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  dec;
  logic [4:0]  shift;
  logic        clr;
  logic [23:0] din;
  logic        dvld;
  logic [3:0]  dch;
  logic [15:0] dout;
  logic [3:0]  dout_ch;
  logic        dout_vld;
  logic        dout_rdy;
  logic [15:0] drop_cnt;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  logic [19:0] sb[$];

  always #5 clk = ~clk;

  fir_out_decim dut (
    .CLK            (clk),
    .RST            (rst),
    .Dec_Factor     (dec),
    .Shift          (shift),
    .Status_Clr     (clr),
    .Data_In        (din),
    .Data_In_Valid  (dvld),
    .Data_In_ChIdx  (dch),
    .Data_Out       (dout),
    .Data_Out_ChIdx (dout_ch),
    .Data_Out_Valid (dout_vld),
    .Data_Out_Ready (dout_rdy),
    .Drop_Cnt       (drop_cnt),
    .Ovf_Sticky     (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: every accepted output word is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && dout_vld && dout_rdy) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {12'h0, dout_ch, dout}, 32'hFFFFFFFF);
      end else begin
        logic [19:0] e;
        e = sb.pop_front();
        check("out_word", {12'h0, dout_ch, dout}, {12'h0, e});
      end
    end
  end

  task automatic send(input logic [3:0] ch, input logic [23:0] d, input int hold);
    @(posedge clk); #1;
    din = d; dch = ch; dvld = 1'b1;
    repeat (hold) @(posedge clk);
    #1 dvld = 1'b0;
  endtask

  task automatic expect_out(input logic [3:0] ch, input logic [15:0] d);
    sb.push_back({ch, d});
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1 check(name, sb.size(), 0);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dec = 8'd1; shift = 5'd8; clr = 1'b0;
    din = '0; dvld = 1'b0; dch = '0; dout_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", dout_vld, 0);
    check("reset_data", dout, 0);
    check("reset_drop", drop_cnt, 0);
    check("reset_ovf", ovf, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Rounding with Shift=8 and two-cycle latency from capture.
    expect_out(4'd0, 16'h0002);
    send(4'd0, 24'h000180, 1);
    @(negedge clk);
    @(negedge clk);
    check("latency_e1_valid", dout_vld, 0);
    @(negedge clk);
    check("latency_e2_valid", dout_vld, 1);
    expect_out(4'd0, 16'hFFFF);
    send(4'd0, 24'hFFFE80, 1);
    wait_drain("drain_round", 50);

    // Decimate by 3 on two interleaved channels.
    @(posedge clk); #1 dec = 8'd3; shift = 5'd0;
    repeat (3) @(posedge clk);
    expect_out(4'd0, 16'd1);
    expect_out(4'd1, 16'd101);
    expect_out(4'd0, 16'd4);
    expect_out(4'd1, 16'd104);
    for (int i = 1; i <= 6; i++) begin
      send(4'd0, 24'(i), 1);
      send(4'd1, 24'(100 + i), 1);
    end
    wait_drain("drain_decim", 50);

    // Out-of-range sample: clamp or wrap depending on build.
    @(posedge clk); #1 dec = 8'd1;
    repeat (3) @(posedge clk);
`ifdef FIR_OUT_DECIM_SAT_EN
    expect_out(4'd0, 16'h7FFF);
    send(4'd0, 24'h012345, 1);
    wait_drain("drain_sat", 50);
    check("ovf_set", ovf, 1);
`else
    expect_out(4'd0, 16'h2345);
    send(4'd0, 24'h012345, 1);
    wait_drain("drain_sat", 50);
    check("ovf_set", ovf, 0);
`endif
    pulse_clr();
    #1 check("ovf_cleared", ovf, 0);

    // Fill with Ready low: 8 stored, 2 dropped, then an in-order drain.
    @(posedge clk); #1 dout_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) expect_out(4'd1, 16'(16'h0010 + i));
      send(4'd1, 24'(24'h10 + i), 1);
    end
    repeat (4) @(posedge clk);
    #1 check("drop_cnt_full", drop_cnt, 2);
    check("full_head", {dout_ch, dout}, {4'd1, 16'h0010});
    @(posedge clk); #1 dout_rdy = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("drain_8_cycles", sb.size(), 0);
    check("drained_valid", dout_vld, 0);

    // Held valid yields one sample; an out-of-range channel yields none.
    expect_out(4'd0, 16'd5);
    send(4'd0, 24'd5, 3);
    send(4'd3, 24'd9, 1);
    wait_drain("drain_held", 50);
    check("drop_unchanged", drop_cnt, 2);

    // Reset while the FIFO holds 4 words, with a channel phase left mid-count.
    @(posedge clk); #1 dec = 8'd2; dout_rdy = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 7; i++) send(4'd0, 24'(24'h40 + i), 1);
    repeat (4) @(posedge clk);
    #1 check("pre_reset_head", {dout_ch, dout}, {4'd0, 16'h0040});
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_valid", dout_vld, 0);
    check("rst_drop", drop_cnt, 0);
    rst = 1'b0; dout_rdy = 1'b1;
    repeat (2) @(posedge clk);
    expect_out(4'd0, 16'd77);
    send(4'd0, 24'd77, 1);
    wait_drain("drain_after_rst", 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
